// File: rtl/wb_arbiter2_rr.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter2_rr
// Purpose  : Two-master round-robin Wishbone classic arbiter with bus lock
//            and per-transfer ack timeout.
// Revision : 1.0
// ============================================================================
module wb_arbiter2_rr #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic [ADDR_WIDTH-3:0] m0_wb_adr_i,
    input  logic [31:0]           m0_wb_dat_i,
    output logic [31:0]           m0_wb_dat_o,
    input  logic                  m0_wb_we_i,
    input  logic [3:0]            m0_wb_sel_i,
    input  logic                  m0_wb_cyc_i,
    input  logic                  m0_wb_stb_i,
    output logic                  m0_wb_ack_o,
    output logic                  m0_wb_err_o,

    input  logic [ADDR_WIDTH-3:0] m1_wb_adr_i,
    input  logic [31:0]           m1_wb_dat_i,
    output logic [31:0]           m1_wb_dat_o,
    input  logic                  m1_wb_we_i,
    input  logic [3:0]            m1_wb_sel_i,
    input  logic                  m1_wb_cyc_i,
    input  logic                  m1_wb_stb_i,
    output logic                  m1_wb_ack_o,
    output logic                  m1_wb_err_o,

    output logic [ADDR_WIDTH-3:0] s_wb_adr_o,
    output logic [31:0]           s_wb_dat_o,
    input  logic [31:0]           s_wb_dat_i,
    output logic                  s_wb_we_o,
    output logic [3:0]            s_wb_sel_o,
    output logic                  s_wb_cyc_o,
    output logic                  s_wb_stb_o,
    input  logic                  s_wb_ack_i
);

    // A zero timeout still needs a legal one-bit counter.
    localparam int              CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit              TMO_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic gnt0;
    logic gnt1;
    logic stb_req;
    logic hit;

    assign gnt0    = (state == GNT0);
    assign gnt1    = (state == GNT1);
    assign hit     = TMO_EN && (cnt == CNT_MAX);
    assign stb_req = (gnt0 & m0_wb_stb_i) | (gnt1 & m1_wb_stb_i);

    assign s_wb_adr_o = gnt1 ? m1_wb_adr_i : m0_wb_adr_i;
    assign s_wb_dat_o = gnt1 ? m1_wb_dat_i : m0_wb_dat_i;
    assign s_wb_we_o  = gnt1 ? m1_wb_we_i  : m0_wb_we_i;
    assign s_wb_sel_o = gnt1 ? m1_wb_sel_i : m0_wb_sel_i;
    assign s_wb_cyc_o = (gnt0 & m0_wb_cyc_i) | (gnt1 & m1_wb_cyc_i);
    assign s_wb_stb_o = stb_req & ~hit;

    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;
    assign m0_wb_ack_o = gnt0 & s_wb_ack_i;
    assign m1_wb_ack_o = gnt1 & s_wb_ack_i;
    // A late ack beats a simultaneous timeout.
    assign m0_wb_err_o = gnt0 & hit & ~s_wb_ack_i;
    assign m1_wb_err_o = gnt1 & hit & ~s_wb_ack_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            if (s_wb_ack_i || hit) begin
                cnt <= '0;
            end else if (s_wb_stb_o) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (m0_wb_cyc_i && (!m1_wb_cyc_i || last)) begin
                        state <= GNT0;
                        cnt   <= '0;
                    end else if (m1_wb_cyc_i) begin
                        state <= GNT1;
                        cnt   <= '0;
                    end
                end
                GNT0: begin
                    if (!m0_wb_cyc_i) begin
                        last  <= 1'b0;
                        cnt   <= '0;
                        state <= m1_wb_cyc_i ? GNT1 : IDLE;
                    end
                end
                GNT1: begin
                    if (!m1_wb_cyc_i) begin
                        last  <= 1'b1;
                        cnt   <= '0;
                        state <= m0_wb_cyc_i ? GNT0 : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter2_rr
// Purpose  : Directed self-checking bench for wb_arbiter2_rr with a small
//            1-cycle-ack SRAM slave model.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter2_rr;

    logic        clk;
    logic        rst;

    logic [29:0] m0_adr, m1_adr;
    logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat;
    logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack, m0_err, m1_err;

    logic [29:0] s_adr;
    logic [31:0] s_wdat, s_rdat;
    logic        s_we, s_cyc, s_stb, s_ack;
    logic [3:0]  s_sel;

    logic [31:0] mem [0:15];
    logic        ack_en;
    logic        watch_m1;
    logic        m1_seen;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter2_rr #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .m0_wb_adr_i (m0_adr),
        .m0_wb_dat_i (m0_wdat),
        .m0_wb_dat_o (m0_rdat),
        .m0_wb_we_i  (m0_we),
        .m0_wb_sel_i (m0_sel),
        .m0_wb_cyc_i (m0_cyc),
        .m0_wb_stb_i (m0_stb),
        .m0_wb_ack_o (m0_ack),
        .m0_wb_err_o (m0_err),
        .m1_wb_adr_i (m1_adr),
        .m1_wb_dat_i (m1_wdat),
        .m1_wb_dat_o (m1_rdat),
        .m1_wb_we_i  (m1_we),
        .m1_wb_sel_i (m1_sel),
        .m1_wb_cyc_i (m1_cyc),
        .m1_wb_stb_i (m1_stb),
        .m1_wb_ack_o (m1_ack),
        .m1_wb_err_o (m1_err),
        .s_wb_adr_o  (s_adr),
        .s_wb_dat_o  (s_wdat),
        .s_wb_dat_i  (s_rdat),
        .s_wb_we_o   (s_we),
        .s_wb_sel_o  (s_sel),
        .s_wb_cyc_o  (s_cyc),
        .s_wb_stb_o  (s_stb),
        .s_wb_ack_i  (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM slave: word i holds 0xA5A5000i except the two preset words.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack  <= 1'b0;
            s_rdat <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= {16'hA5A5, 12'h000, i[3:0]};
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'h11223344;
        end else begin
            s_ack <= 1'b0;
            if (s_cyc && s_stb && !s_ack && ack_en) begin
                s_ack  <= 1'b1;
                s_rdat <= mem[s_adr[3:0]];
                if (s_we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) mem[s_adr[3:0]][8*b +: 8] <= s_wdat[8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) if (watch_m1 && m1_ack) m1_seen <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a drive point; returns mid-cycle of the ack.
    task automatic wait_ack(input int m, output logic [31:0] d);
        bit ok;
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 10; i++) begin
            #4;
            if ((m == 0) ? m0_ack : m1_ack) begin
                ok = 1'b1;
                d  = (m == 0) ? m0_rdat : m1_rdat;
                break;
            end
            @(posedge clk); #1;
        end
        check("ack_wait", {31'd0, ok}, 32'd1);
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = '0; m1_wdat = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int errs, acks;
        rst = 1'b1; ack_en = 1'b1; watch_m1 = 1'b0; m1_seen = 1'b0;
        clear_inputs();
        #2;
        check("rst_stb", {31'd0, s_stb}, 32'd0);
        check("rst_cyc", {31'd0, s_cyc}, 32'd0);
        check("rst_ack0", {31'd0, m0_ack}, 32'd0);
        check("rst_err0", {31'd0, m0_err}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency: request at T0, stb at T1, ack with data at T2
        m0_adr = 30'd4; m0_cyc = 1; m0_stb = 1;
        #4 check("t1_stb_T0", {31'd0, s_stb}, 32'd0);
        @(posedge clk); #1; #4;
        check("t1_stb_T1", {31'd0, s_stb}, 32'd1);
        check("t1_adr", {2'b0, s_adr}, 32'd4);
        check("t1_ack_T1", {31'd0, m0_ack}, 32'd0);
        @(posedge clk); #1; #4;
        check("t1_ack_T2", {31'd0, m0_ack}, 32'd1);
        check("t1_data", m0_rdat, 32'hDEADBEEF);
        @(posedge clk); #1;
        m0_cyc = 0; m0_stb = 0;
        do_reset();

        // Round robin after reset: m0 first, m1 with no bubble, then m0 again
        m0_adr = 30'd1; m1_adr = 30'd2;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        wait_ack(0, d);
        check("t2_m0_data", d, 32'hA5A50001);
        check("t2_m1_noack", {31'd0, m1_ack}, 32'd0);
        @(posedge clk); #1;
        m0_cyc = 0; m0_stb = 0;
        @(posedge clk); #1; #4;
        check("t2_nobubble_stb", {31'd0, s_stb}, 32'd1);
        check("t2_nobubble_adr", {2'b0, s_adr}, 32'd2);
        @(posedge clk); #1; #4;
        check("t2_m1_ack", {31'd0, m1_ack}, 32'd1);
        check("t2_m1_data", m1_rdat, 32'hA5A50002);
        @(posedge clk); #1;
        m1_cyc = 0; m1_stb = 0;
        @(posedge clk); #1;
        m0_adr = 30'd3;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        wait_ack(0, d);
        check("t2_again_m0", d, 32'hA5A50003);
        check("t2_again_m1_noack", {31'd0, m1_ack}, 32'd0);
        @(posedge clk); #1;
        clear_inputs();

        // Bus lock: m0 keeps cyc across three reads while m1 waits
        @(posedge clk); #1;
        m0_adr = 30'd5; m0_cyc = 1; m0_stb = 1;
        @(posedge clk); #1;
        m1_adr = 30'd6; m1_cyc = 1; m1_stb = 1;
        watch_m1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m0_adr = 30'(5 + k); m0_stb = 1;
            wait_ack(0, d);
            check("t3_m0_data", d, 32'hA5A50005 + 32'(k));
            @(posedge clk); #1;
            m0_stb = 0;
            @(posedge clk); #1;
        end
        check("t3_lock", {31'd0, m1_seen}, 32'd0);
        watch_m1 = 1'b0;
        m0_cyc = 0;
        wait_ack(1, d);
        check("t3_m1_data", d, 32'hA5A50006);
        @(posedge clk); #1;
        clear_inputs();

        // Byte-lane write then readback
        @(posedge clk); #1;
        m1_we = 1; m1_adr = 30'd8; m1_sel = 4'b0010; m1_wdat = 32'h0000AB00;
        m1_cyc = 1; m1_stb = 1;
        wait_ack(1, d);
        @(posedge clk); #1;
        m1_cyc = 0; m1_stb = 0;
        @(posedge clk); #1;
        m1_we = 0; m1_sel = 4'hF; m1_cyc = 1; m1_stb = 1;
        wait_ack(1, d);
        check("t4_readback", d, 32'h1122AB44);
        @(posedge clk); #1;
        clear_inputs();

        // Timeout with a silent slave
        @(posedge clk); #1;
        ack_en = 1'b0; errs = 0; acks = 0;
        m0_adr = 30'd3; m0_cyc = 1; m0_stb = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) begin m0_cyc = 0; m0_stb = 0; end
            #4;
            if (m0_err) errs++;
            if (m0_ack) acks++;
            if (i == 4) check("t5_stb_c4", {31'd0, s_stb}, 32'd1);
            if (i == 5) begin
                check("t5_hit_stb", {31'd0, s_stb}, 32'd0);
                check("t5_hit_err", {31'd0, m0_err}, 32'd1);
            end
            @(posedge clk); #1;
        end
        check("t5_err_count", 32'(errs), 32'd1);
        check("t5_ack_count", 32'(acks), 32'd0);
        ack_en = 1'b1;

        // Reset in the middle of an m1 transfer
        m1_adr = 30'd2; m1_cyc = 1; m1_stb = 1;
        @(posedge clk); #1; #4;
        check("t6_stb", {31'd0, s_stb}, 32'd1);
        @(posedge clk); #1; #4;
        check("t6_ack_pre", {31'd0, m1_ack}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_stb_rst", {31'd0, s_stb}, 32'd0);
        check("t6_cyc_rst", {31'd0, s_cyc}, 32'd0);
        check("t6_ack_rst", {31'd0, m1_ack}, 32'd0);
        @(posedge clk); #1;
        m0_adr = 30'd1; m0_cyc = 1; m0_stb = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        #4 check("t6_idle_stb", {31'd0, s_stb}, 32'd0);
        @(posedge clk); #1; #4;
        check("t6_gnt_stb", {31'd0, s_stb}, 32'd1);
        check("t6_m0_first", {2'b0, s_adr}, 32'd1);
        @(posedge clk); #1;
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
